seq_capture: RTL
================

SEQ_CAPTURE -- requirements
Module: seq_capture

Interface
REQ-001 Parameter WORD_W, default 8, SHALL set the deserialized word width (legal range 2..16).
REQ-002 Port clk  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-003 Port reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 Port bit_in  input  1  SHALL carry the serial bit from the upstream sequence generator output y.
REQ-005 Port bit_valid  input  1  SHALL qualify bit_in; bit_in is sampled only on cycles where bit_valid=1.
REQ-006 Port word_data  output  WORD_W  SHALL present the captured word.
REQ-007 Port word_valid  output  1  SHALL indicate word_data holds an unconsumed word.
REQ-008 Port word_ready  input  1  SHALL indicate the consumer accepts word_data this cycle.
REQ-009 Port match  output  1  SHALL pulse for one cycle per detected 1101 pattern.
REQ-010 Port match_count  output  8  SHALL hold the number of detected patterns, saturating.
REQ-011 Port overrun  output  1  SHALL be a sticky flag for a dropped word.

Function
REQ-012 Deserializer SHALL shift bit_in in MSB-first; the first accepted bit of a word lands in word_data[WORD_W-1].
REQ-013 A bit counter (0..WORD_W-1) SHALL increment per accepted bit and wrap to 0 on the WORD_W-th bit.
REQ-014 The completed word SHALL be loaded into the output holding register on the edge that accepts its WORD_W-th bit; word_valid=1 from the following cycle (latency 1 clock after last bit).
REQ-015 Transfer SHALL occur on any cycle with word_valid=1 and word_ready=1; word_valid drops next cycle unless a new word loads that same edge.
REQ-016 word_data and word_valid SHALL remain stable while word_valid=1 and word_ready=0.
REQ-017 Word completing while holding register full and not transferred that cycle: new word SHALL be discarded, held word retained, overrun set to 1.
REQ-018 Word completing on the same edge as a transfer: new word SHALL load, word_valid stays 1, no overrun.
REQ-019 Cycles with bit_valid=0 SHALL not change shift register, bit counter or detector state.
REQ-020 Detector FSM states: IDLE, S1 (seen 1), S11 (seen 11), S110 (seen 110); evaluated only on accepted bits.
REQ-021 Transitions: IDLE -1->S1, -0->IDLE; S1 -1->S11, -0->IDLE; S11 -1->S11, -0->S110; S110 -1->S1 with match, -0->IDLE.
REQ-022 Detection SHALL be overlapping and independent of word boundaries.
REQ-023 match SHALL be registered: high exactly the cycle after the accepting edge of the final 1.
REQ-024 match_count SHALL increment with each match and hold at 255.

Reset
REQ-025 On reset: word_data=0, word_valid=0, match=0, match_count=0, overrun=0, FSM=IDLE, bit counter=0, shift register=0.
REQ-026 Reset mid-word SHALL discard the partial word; the next accepted bit after release is bit 0 of a new word.
REQ-027 overrun SHALL clear only by reset.

Structure
REQ-028 Package seq_pkg SHALL hold the detector state enum typedef, the WORD_W default constant and the match_count saturation constant (255).
REQ-029 The detector FSM SHALL be a sub-module seq_detect_1101 (ports clk, reset, bit_in, bit_valid, match); deserializer, handshake and counter stay in seq_capture.

Verification
REQ-030 Reset then bits 1,0,1,1,0,0,1,0 with bit_valid=1, word_ready=1 -> word_valid=1 one cycle after 8th bit, word_data=8'hB2.
REQ-031 Stream 1,1,0,1,1,0,1 -> match pulses twice (after bits 4 and 7), match_count=2.
REQ-032 word_ready=0, two full words sent -> first word held stable, second dropped, overrun=1; raising word_ready transfers first word only.
REQ-033 word_ready asserted on the exact cycle second word completes -> first transfers, second loads, word_valid stays 1, overrun=0.
REQ-034 Assert reset after 5 bits, release, send 8 bits of 8'h0F -> word_data=8'h0F, no remnant bits.
REQ-035 Send 1101 repeated 300 times with bit_valid toggling 1/0 -> match_count=255, no state change on bit_valid=0 cycles.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and constants for the serial capture path: detector state encoding,
// default word width and the saturation ceiling of the pattern counter.
package seq_pkg;

  localparam int WORD_W_DEFAULT = 8;
  localparam logic [7:0] MATCH_MAX = 8'd255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S1   = 2'd1,
    S11  = 2'd2,
    S110 = 2'd3
  } det_state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == MATCH_MAX) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/seq_detect_1101.sv
// Overlapping 1101 detector advanced only on qualified bits; match is registered,
// high the cycle after the edge that accepts the final 1. No backpressure.
module seq_detect_1101
  import seq_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic bit_in,
  input  logic bit_valid,
  output logic match
);

  det_state_t state;
  det_state_t state_next;
  logic       hit;

  always_comb begin
    state_next = state;
    hit        = 1'b0;
    if (bit_valid) begin
      case (state)
        IDLE:    state_next = bit_in ? S1  : IDLE;
        S1:      state_next = bit_in ? S11 : IDLE;
        S11:     state_next = bit_in ? S11 : S110;
        S110: begin
          // The trailing 1 of a hit is also the leading 1 of the next pattern.
          state_next = bit_in ? S1 : IDLE;
          hit        = bit_in;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      match <= 1'b0;
    end else begin
      state <= state_next;
      match <= hit;
    end
  end

endmodule

// File: rtl/seq_capture.sv
// MSB-first deserializer with a one-word valid/ready holding register (1 clock after last bit),
// a saturating 1101 counter and a sticky overrun flag; a word completing against a full, stalled register is dropped.
module seq_capture
  import seq_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              match,
  output logic [7:0]        match_count,
  output logic              overrun
);

  localparam int CNT_W = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

  // Only the first WORD_W-1 bits need storage; the last bit goes straight into the word.
  logic [WORD_W-2:0] shift_reg;
  logic [CNT_W-1:0]  bit_cnt;
  logic              word_done;
  logic              transfer;
  logic              load;
  logic [WORD_W-1:0] full_word;

  assign word_done = bit_valid && (bit_cnt == LAST_BIT);
  assign transfer  = word_valid && word_ready;
  assign load      = word_done && (!word_valid || transfer);
  assign full_word = {shift_reg, bit_in};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (bit_valid) begin
      shift_reg <= full_word[WORD_W-2:0];
      bit_cnt   <= word_done ? '0 : bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_data  <= '0;
      word_valid <= 1'b0;
    end else if (load) begin
      word_data  <= full_word;
      word_valid <= 1'b1;
    end else if (transfer) begin
      word_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (word_done && word_valid && !word_ready) begin
      overrun <= 1'b1;
    end
  end

  seq_detect_1101 u_detect (
    .clk       (clk),
    .reset     (reset),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .match     (match)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_count <= '0;
    end else if (match) begin
      match_count <= sat_inc(match_count);
    end
  end

endmodule
